// File: rtl/uart_rx_ext.sv
// uart_rx_ext: runtime-configurable UART receiver.
// Synchronises rxd and decides each bit by a 3-sample majority vote around mid-bit.
// It detects false starts, parity errors, framing errors, breaks and overruns.
// Completed frames are queued in a first-word-fall-through FIFO with a valid/ready output.
module uart_rx_ext #(
    parameter int MAX_DATA_BITS   = 8,
    parameter int DIV_WIDTH       = 16,
    parameter int SYNC_STAGES     = 3,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     sclk,
    input  logic                     reset,
    input  logic                     rxd,
    input  logic                     cfg_en,
    input  logic [DIV_WIDTH-1:0]     cfg_div,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    output logic [MAX_DATA_BITS-1:0] m_data,
    output logic                     m_perr,
    output logic                     m_ferr,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overrun,
    output logic                     break_det,
    output logic                     busy
);
    localparam int                       DEPTH    = 2 ** FIFO_DEPTH_LOG2;
    localparam int                       WORD_W   = MAX_DATA_BITS + 2;
    localparam logic [3:0]               MIN_NB   = 4'd5;
    localparam logic [3:0]               MAX_NB   = 4'(MAX_DATA_BITS);
    localparam logic [DIV_WIDTH-1:0]     MIN_DIV  = DIV_WIDTH'(7);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LVL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

    state_t                     state, state_next;
    logic [SYNC_STAGES-1:0]     sync_q;
    logic                       rxd_s, rxd_prev;
    logic [DIV_WIDTH-1:0]       cnt, div_q, div_eff, half;
    logic [3:0]                 nb_q, nb_eff, bit_idx;
    logic [1:0]                 par_q;
    logic                       stop2_q, par_en, par_odd;
    logic                       s0, s1, vote, timed;
    logic                       at_s0, at_s1, at_vote, at_end, last_bit, is_break;
    logic [MAX_DATA_BITS-1:0]   data_q;
    logic                       par_acc, par_bit, perr_q;
    logic                       frame_start, frame_push, frame_brk, stop_fail;
    logic                       push_q, brk_q;
    logic [WORD_W-1:0]          push_word, head;
    logic [WORD_W-1:0]          mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr, rptr;
    logic                       full, pop, do_push;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain and previous-sample flop for start-edge detection.
    always_ff @(posedge sclk) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync_q   <= '1;
            rxd_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_prev <= rxd_s;
        end
    end

    // Effective configuration, bit-timing strobes and the majority vote.
    always_comb begin
        div_eff = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
        if (cfg_data_bits < MIN_NB)      nb_eff = MIN_NB;
        else if (cfg_data_bits > MAX_NB) nb_eff = MAX_NB;
        else                             nb_eff = cfg_data_bits;
        par_en   = par_q[0] ^ par_q[1];
        par_odd  = (par_q == 2'b01);
        half     = div_q >> 1;
        at_s0    = (cnt == half - DIV_WIDTH'(1));
        at_s1    = (cnt == half);
        at_vote  = (cnt == half + DIV_WIDTH'(1));
        at_end   = (cnt == div_q);
        vote     = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
        timed    = state inside {START, DATA, PARITY, STOP1, STOP2};
        last_bit = (bit_idx == nb_q - 4'd1);
        is_break = (data_q == '0) && !(par_en && par_bit);
    end

    // State register.
    always_ff @(posedge sclk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-frame control strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_next  = state;
        frame_start = 1'b0;
        frame_push  = 1'b0;
        frame_brk   = 1'b0;
        stop_fail   = 1'b0;
        case (state)
            IDLE: if (rxd_prev && !rxd_s) begin
                state_next  = START;
                frame_start = 1'b1;
            end
            START: begin
                if (at_vote && vote) state_next = IDLE;
                else if (at_end)     state_next = DATA;
            end
            DATA:   if (at_end && last_bit) state_next = par_en ? PARITY : STOP1;
            PARITY: if (at_end) state_next = STOP1;
            STOP1: begin
                if (at_vote) begin
                    if (!vote && is_break) begin
                        frame_brk  = 1'b1;
                        state_next = WAIT_HIGH;
                    end else if (!vote) begin
                        frame_push = 1'b1;
                        stop_fail  = 1'b1;
                        state_next = WAIT_HIGH;
                    end else if (!stop2_q) begin
                        frame_push = 1'b1;
                        state_next = IDLE;
                    end
                end else if (at_end && stop2_q) begin
                    state_next = STOP2;
                end
            end
            STOP2: if (at_vote) begin
                frame_push = 1'b1;
                stop_fail  = !vote;
                state_next = vote ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: if (rxd_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (!cfg_en) begin
            state_next  = IDLE;
            frame_start = 1'b0;
            frame_push  = 1'b0;
            frame_brk   = 1'b0;
        end
    end

    // Bit counter, sample capture, data shift register and parity accumulation.
    always_ff @(posedge sclk) begin
        if (reset) begin
            cnt     <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            data_q  <= '0;
            bit_idx <= '0;
            par_acc <= 1'b0;
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
            div_q   <= MIN_DIV;
            nb_q    <= MAX_NB;
            par_q   <= '0;
            stop2_q <= 1'b0;
        end else if (frame_start) begin
            cnt     <= '0;
            data_q  <= '0;
            bit_idx <= '0;
            par_acc <= 1'b0;
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
            div_q   <= div_eff;
            nb_q    <= nb_eff;
            par_q   <= cfg_parity;
            stop2_q <= cfg_stop2;
        end else if (timed) begin
            cnt <= at_end ? '0 : cnt + DIV_WIDTH'(1);
            if (at_s0) s0 <= rxd_s;
            if (at_s1) s1 <= rxd_s;
            if (state == DATA && at_vote) begin
                // LSB arrives first; shifting in at the MSB leaves N bits in the top of data_q.
                data_q  <= {vote, data_q[MAX_DATA_BITS-1:1]};
                par_acc <= par_acc ^ vote;
            end
            if (state == DATA && at_end) bit_idx <= bit_idx + 4'd1;
            if (state == PARITY && at_vote) begin
                par_bit <= vote;
                perr_q  <= par_acc ^ vote ^ par_odd;
            end
        end
    end

    // Push and break strobes fire the cycle after the deciding stop-bit vote.
    always_ff @(posedge sclk) begin
        if (reset) begin
            push_q    <= 1'b0;
            brk_q     <= 1'b0;
            push_word <= '0;
        end else begin
            push_q <= frame_push;
            brk_q  <= frame_brk;
            if (frame_push) push_word <= {stop_fail, perr_q, data_q >> (MAX_NB - nb_q)};
        end
    end

    assign full    = (fifo_level == FULL_LVL);
    assign m_valid = (fifo_level != '0);
    assign pop     = m_valid && m_ready;
    assign do_push = push_q && (!full || pop);
    assign overrun = push_q && full && !pop;
    assign head    = mem[rptr];

    // FIFO storage: data only, qualified by fifo_level.
    always_ff @(posedge sclk) begin
        // NOTE: the memory array has no reset; empty entries are never exposed because outputs are gated by m_valid.
        if (do_push) mem[wptr] <= push_word;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sclk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({do_push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign m_data    = m_valid ? head[MAX_DATA_BITS-1:0] : '0;
    assign m_perr    = m_valid & head[MAX_DATA_BITS];
    assign m_ferr    = m_valid & head[MAX_DATA_BITS+1];
    assign break_det = brk_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed self-checking bench for uart_rx_ext.
// Frames are driven bit by bit on the falling clock edge, and outputs are sampled on the falling edge.
module tb_uart_rx_ext;
    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        cfg_en = 1'b1;
    logic [15:0] cfg_div = 16'd15;
    logic [3:0]  cfg_data_bits = 4'd8;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_perr, m_ferr, m_valid;
    logic [2:0]  fifo_level;
    logic        overrun, break_det, busy;

    int n_cmp = 0;
    int n_err = 0;
    int bit_len = 16;
    int ovr_cnt = 0;
    int brk_cnt = 0;
    int busy_cnt = 0;

    uart_rx_ext #(
        .MAX_DATA_BITS(8), .DIV_WIDTH(16), .SYNC_STAGES(3), .FIFO_DEPTH_LOG2(2)
    ) dut (
        .sclk(sclk), .reset(reset), .rxd(rxd), .cfg_en(cfg_en), .cfg_div(cfg_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_level(fifo_level), .overrun(overrun),
        .break_det(break_det), .busy(busy)
    );

    always #5 sclk = ~sclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One falling edge; pulse outputs are tallied here.
    task automatic tick();
        @(negedge sclk);
        ovr_cnt  += int'(overrun);
        brk_cnt  += int'(break_det);
        busy_cnt += int'(busy);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (bit_len) tick();
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                              input logic par_bit, input logic stop_a,
                              input logic two_stop, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop_a);
        if (two_stop) drive_bit(stop_b);
    endtask

    // Check the FIFO head against expectations, then pop it.
    task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_data"}, m_data, d);
        check({tag, "_perr"}, m_perr, pe);
        check({tag, "_ferr"}, m_ferr, fe);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] v;

        // Reset state.
        repeat (4) tick();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_perr", m_perr, 0);
        check("rst_ferr", m_ferr, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_break", break_det, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        idle_bits(2);

        // 8N1 0xA5 with exact m_valid latency: the stop vote lands 156 edges after the start edge.
        v = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        rxd = 1'b1;
        repeat (13) tick();
        check("t1_valid_before", m_valid, 0);
        tick();
        check("t1_valid_rise", m_valid, 1);
        check("t1_level", fifo_level, 1);
        repeat (2) tick();
        idle_bits(1);
        pop_check("t1", 8'hA5, 0, 0);
        check("t1_level_after_pop", fifo_level, 0);

        // 7E1: wrong parity, then correct parity; then 7O1 with parity bit 1.
        cfg_data_bits = 4'd7;
        cfg_parity    = 2'b10;
        send_frame(8'h41, 7, 1, 1, 1, 0, 0);
        send_frame(8'h41, 7, 1, 0, 1, 0, 0);
        idle_bits(1);
        check("t2_level", fifo_level, 2);
        check("t2_msb", m_data[7], 0);
        pop_check("t2_bad", 8'h41, 1, 0);
        pop_check("t2_good", 8'h41, 0, 0);
        cfg_parity = 2'b01;
        send_frame(8'h41, 7, 1, 1, 1, 0, 0);
        idle_bits(1);
        pop_check("t2_odd", 8'h41, 0, 0);

        // 8N2 with second stop bit low, then the line held low for 3 bit times.
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b1;
        send_frame(8'h55, 8, 0, 0, 1, 1, 0);
        repeat (3 * bit_len) tick();
        check("t3_wait_high", busy, 1);
        check("t3_level_low", fifo_level, 1);
        idle_bits(2);
        check("t3_idle", busy, 0);
        check("t3_level", fifo_level, 1);
        pop_check("t3", 8'h55, 0, 1);
        cfg_stop2 = 1'b0;

        // Break: 12 bit times low, then a normal frame.
        brk_cnt = 0;
        repeat (12) drive_bit(1'b0);
        idle_bits(2);
        check("t4_break_pulses", brk_cnt, 1);
        check("t4_no_entry", fifo_level, 0);
        send_frame(8'h3C, 8, 0, 0, 1, 0, 0);
        idle_bits(1);
        pop_check("t4", 8'h3C, 0, 0);

        // Overrun: five frames into a four-entry FIFO with no consumer.
        ovr_cnt = 0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 8, 0, 0, 1, 0, 0);
        idle_bits(1);
        check("t5_level_full", fifo_level, 4);
        check("t5_overrun_pulses", ovr_cnt, 1);
        for (int k = 1; k <= 4; k++) pop_check("t5_pop", 8'(k), 0, 0);
        check("t5_level_empty", fifo_level, 0);

        // Push and pop in the same cycle while full.
        ovr_cnt = 0;
        for (int k = 1; k <= 4; k++) send_frame(8'h10 + 8'(k), 8, 0, 0, 1, 0, 0);
        idle_bits(1);
        check("t5b_level_full", fifo_level, 4);
        v = 8'h15;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        rxd = 1'b1;
        repeat (12) tick();
        @(negedge sclk);
        m_ready = 1'b1;
        #1;
        ovr_cnt += int'(overrun);
        tick();
        m_ready = 1'b0;
        repeat (2) tick();
        idle_bits(1);
        check("t5b_no_overrun", ovr_cnt, 0);
        check("t5b_level", fifo_level, 4);
        for (int k = 2; k <= 5; k++) pop_check("t5b_pop", 8'h10 + 8'(k), 0, 0);

        // 2-cycle glitch: START for exactly 9 cycles, then rejected.
        busy_cnt = 0;
        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        repeat (32) tick();
        check("t6_busy_cycles", busy_cnt, 9);
        check("t6_busy_end", busy, 0);
        check("t6_no_entry", fifo_level, 0);

        // Reset mid-DATA flushes the FIFO and aborts the frame.
        send_frame(8'h5A, 8, 0, 0, 1, 0, 0);
        idle_bits(1);
        check("t6_pre_level", fifo_level, 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("t6_mid_busy", busy, 1);
        rxd   = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_data", m_data, 0);
        reset = 1'b0;
        idle_bits(1);
        send_frame(8'hC3, 8, 0, 0, 1, 0, 0);
        idle_bits(1);
        pop_check("t6_after_rst", 8'hC3, 0, 0);

        // Config changes after the start edge do not affect the frame in flight.
        v = 8'hA5;
        drive_bit(1'b0);
        cfg_data_bits = 4'd5;
        cfg_parity    = 2'b10;
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        drive_bit(1'b1);
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        idle_bits(1);
        pop_check("cfg_latch", 8'hA5, 0, 0);

        // Divisor below 7 acts as 7 (8-cycle bits); data_bits below 5 acts as 5.
        cfg_div = 16'd2;
        bit_len = 8;
        send_frame(8'h96, 8, 0, 0, 1, 0, 0);
        idle_bits(2);
        pop_check("div_clamp", 8'h96, 0, 0);
        cfg_div       = 16'd15;
        bit_len       = 16;
        cfg_data_bits = 4'd3;
        send_frame(8'h15, 5, 0, 0, 1, 0, 0);
        idle_bits(1);
        pop_check("nb_clamp", 8'h15, 0, 0);
        check("final_level", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Runtime-configurable UART receiver that extends the fixed-format receiver.
- Programmable baud divisor, data bits (5..MAX_DATA_BITS), parity (none/odd/even) and 1 or 2 stop bits.
- Mid-bit 3-sample majority vote; false-start rejection; parity, framing, break and overrun detection.
- Received frames go through an internal first-word-fall-through FIFO with a valid/ready output. Sits between the board UART pin (e.g. GPS/debug) and the register/control fabric.

Parameters:
MAX_DATA_BITS, 8, widest supported data field; also the m_data width.
DIV_WIDTH, 16, width of cfg_div.
SYNC_STAGES, 3, rxd synchroniser depth (>=2).
FIFO_DEPTH_LOG2, 2, FIFO depth = 2**FIFO_DEPTH_LOG2.

Ports:
sclk  in  1  clock.
reset  in  1  synchronous, active-high reset.
rxd  in  1  asynchronous serial input, idle high.
cfg_en  in  1  receiver enable.
cfg_div  in  DIV_WIDTH  bit period = cfg_div+1 sclk cycles; values <7 are treated as 7.
cfg_data_bits  in  4  data bits per frame, 5..MAX_DATA_BITS; out-of-range values clamp into that range.
cfg_parity  in  2  00/11 none, 01 odd, 10 even.
cfg_stop2  in  1  1 = two stop bits.
m_data  out  MAX_DATA_BITS  FIFO head data, right-justified, unused MSBs 0.
m_perr  out  1  parity error flag for the head entry.
m_ferr  out  1  framing error flag for the head entry.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer accept.
fifo_level  out  FIFO_DEPTH_LOG2+1  number of stored entries.
overrun  out  1  1-cycle pulse: a frame was dropped because the FIFO was full.
break_det  out  1  1-cycle pulse: break detected.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: synchroniser chain loads all 1s, so no spurious start bit. State = IDLE; FIFO empty; all outputs 0.
- rxd_s is the last synchroniser stage.
- Config latch: cfg_* is captured at the start edge and held for the whole frame. Config changes mid-frame have no effect on that frame.
- Bit timing: counter cnt runs 0..D (D = effective cfg_div). Samples are taken at H-1, H, H+1 with H = D>>1. Bit value = majority of the 3 samples, decided at H+1.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: a cycle with rxd_s=0 after rxd_s=1 on the previous cycle -> START, cnt=0.
- START: voted value 1 -> false start, return to IDLE, nothing pushed. Voted 0 -> continue; at cnt=D -> DATA.
- DATA: LSB first. After N=cfg_data_bits bits -> PARITY if parity is enabled, else STOP1.
- PARITY: perr = (XOR of data bits ^ parity bit) != (odd ? 1 : 0).
- STOP1 / STOP2: voted 0 sets ferr. STOP2 is only entered when cfg_stop2=1.
- Push: the frame is pushed the cycle after the vote of the last stop bit. The FSM does not wait for the end of the stop bit, which allows back-to-back frames.
- Break: all data bits 0, parity bit (if enabled) 0, and STOP1 voted 0 -> break_det pulses 1 cycle, no push, go to WAIT_HIGH.
- Non-break framing error: the frame is pushed with ferr=1, then go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s=1, then IDLE. A line stuck low never retriggers.
- Frame end paths: normal frame -> IDLE after push. Break and non-break framing error -> WAIT_HIGH as above.
- cfg_en=0: FSM forced to IDLE, any partial frame discarded. FIFO contents and the pop path are unaffected.
- FIFO (FWFT): m_valid = level != 0. Pop on m_valid && m_ready.
- Push while full without pop: frame dropped, overrun pulses, contents unchanged.
- Push and pop in the same cycle while full: both execute, level unchanged, no overrun.
- Pop while empty: ignored.
- Latency: m_valid rises 1 cycle after the push cycle, i.e. 2 cycles after the last stop-bit vote.
- Reset mid-frame: immediate return to reset state, FIFO flushed.

Test Plan:
1. 8N1, cfg_div=15, send 0xA5 -> exactly one entry: m_data=0xA5, perr=0, ferr=0; m_valid rises 2 cycles after the stop vote.
2. 7E1, send 0x41 with a deliberately wrong parity bit, then a correct 0x41 -> entries {0x41, perr=1}, {0x41, perr=0}; m_data[7]=0.
3. 8N2, second stop bit 0, data 0x55 -> {0x55, ferr=1}. Line then held low 3 bit times -> no further frames.
4. rxd low for 12 bit times at div=15, then high, then send 0x3C -> one break_det pulse, no entry for the break, then {0x3C} received normally.
5. FIFO_DEPTH_LOG2=2, m_ready=0, send 5 frames 0x01..0x05 -> fifo_level=4, overrun pulses once; pops yield 0x01..0x04. Repeat with m_ready=1 on the push cycle while full -> no overrun.
6. 2-cycle low glitch at div=15 -> busy pulses, no entry. Separately, assert reset mid-DATA -> all outputs 0, FIFO empty, next clean frame received correctly.
